// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters that drive a
// combinational decode stall on RAW hazards or counter saturation.
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int CW   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dec_valid,
  input  logic [$clog2(NREG)-1:0]  src1,
  input  logic                     src1_v,
  input  logic [$clog2(NREG)-1:0]  src2,
  input  logic                     src2_v,
  input  logic [$clog2(NREG)-1:0]  dst,
  input  logic                     dst_we,
  input  logic                     wb_valid,
  input  logic [$clog2(NREG)-1:0]  wb_dst,
  input  logic                     flush,
  output logic                     stall,
  output logic                     issue,
  output logic [NREG-1:0]          busy,
  output logic                     err
);

  localparam int SW = $clog2(NREG);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt [NREG];
  logic raw1, raw2, sat;

  always_comb begin
    raw1  = src1_v & (cnt[src1] != '0);
    raw2  = src2_v & (cnt[src2] != '0);
    sat   = dst_we & (cnt[dst] == CNT_MAX);
    stall = dec_valid & (raw1 | raw2 | sat);
    issue = dec_valid & ~stall & ~flush;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NREG; i++) busy[i] = (cnt[i] != '0);
  end

  // Writeback never bypasses into the stall terms; it only lands at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        logic inc, dec;
        inc = issue & dst_we & (dst == SW'(r));
        dec = wb_valid & (wb_dst == SW'(r)) & (cnt[r] != '0);
        if (inc && !dec)      cnt[r] <= cnt[r] + CW'(1);
        else if (dec && !inc) cnt[r] <= cnt[r] - CW'(1);
      end
      if (wb_valid && cnt[wb_dst] == '0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_valid, src1_v, src2_v, dst_we, wb_valid, flush;
  logic [2:0] src1, src2, dst, wb_dst;
  logic       stall, issue, err;
  logic [7:0] busy;

  int assert_count = 0;
  int fail_count   = 0;

  reg_scoreboard #(.NREG(8), .CW(2)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .src1(src1), .src1_v(src1_v), .src2(src2), .src2_v(src2_v),
    .dst(dst), .dst_we(dst_we), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .flush(flush), .stall(stall), .issue(issue), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyIdle();
    dec_valid = 0; src1_v = 0; src2_v = 0; dst_we = 0; wb_valid = 0; flush = 0;
    src1 = 0; src2 = 0; dst = 0; wb_dst = 0;
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] d);
    applyIdle();
    dec_valid = 1; dst_we = 1; dst = d;
    stepClock();
    applyIdle();
  endtask

  initial begin
    applyIdle();
    rst_n = 0;
    #12 rst_n = 1;
    #1;
    checkOutput("reset_busy",  busy,  8'h00);
    checkOutput("reset_err",   {7'b0, err},   8'h00);
    checkOutput("reset_stall", {7'b0, stall}, 8'h00);
    checkOutput("reset_issue", {7'b0, issue}, 8'h00);

    // RAW hazard on r5 with same-cycle writeback
    stepClock();
    applyStimulus(3'd5);
    checkOutput("raw_busy", busy, 8'h20);
    src1 = 5; src1_v = 1;
    #1 checkOutput("raw_no_dec_valid", {7'b0, stall}, 8'h00);
    dec_valid = 1; wb_valid = 1; wb_dst = 5;
    #1;
    checkOutput("raw_stall",     {7'b0, stall}, 8'h01);
    checkOutput("raw_wb_nobyp",  {7'b0, issue}, 8'h00);
    stepClock();
    wb_valid = 0;
    #1;
    checkOutput("raw_clear_stall", {7'b0, stall}, 8'h00);
    checkOutput("raw_clear_issue", {7'b0, issue}, 8'h01);
    checkOutput("raw_busy_after",  busy, 8'h00);
    stepClock();
    applyIdle();

    // Saturation on r2
    applyStimulus(3'd2);
    applyStimulus(3'd2);
    applyStimulus(3'd2);
    checkOutput("sat_busy", busy, 8'h04);
    dec_valid = 1; dst_we = 1; dst = 2; wb_valid = 1; wb_dst = 2;
    #1 checkOutput("sat_stall", {7'b0, stall}, 8'h01);
    stepClock();
    wb_valid = 0;
    #1 checkOutput("sat_issue_after_wb", {7'b0, issue}, 8'h01);
    stepClock();
    #1 checkOutput("sat_back_to_3", {7'b0, stall}, 8'h01);
    applyIdle();

    // Simultaneous inc/dec on r7
    applyStimulus(3'd7);
    checkOutput("simul_pre", busy, 8'h84);
    dec_valid = 1; dst_we = 1; dst = 7; wb_valid = 1; wb_dst = 7;
    #1 checkOutput("simul_issue", {7'b0, issue}, 8'h01);
    stepClock();
    applyIdle();
    checkOutput("simul_busy", busy, 8'h84);
    wb_valid = 1; wb_dst = 7;
    stepClock();
    applyIdle();
    checkOutput("simul_cnt_was_1", busy, 8'h04);

    // Flush with busy = 8'h15 and a would-be underflow writeback
    applyStimulus(3'd0);
    applyStimulus(3'd4);
    checkOutput("flush_pre", busy, 8'h15);
    dec_valid = 1; dst_we = 1; dst = 1; flush = 1; wb_valid = 1; wb_dst = 6;
    #1;
    checkOutput("flush_issue", {7'b0, issue}, 8'h00);
    checkOutput("flush_stall", {7'b0, stall}, 8'h00);
    stepClock();
    applyIdle();
    checkOutput("flush_busy", busy, 8'h00);
    checkOutput("flush_no_err", {7'b0, err}, 8'h00);

    // Underflow on r4, then err survives a flush
    wb_valid = 1; wb_dst = 4;
    stepClock();
    applyIdle();
    checkOutput("uflow_err",  {7'b0, err}, 8'h01);
    checkOutput("uflow_busy", busy, 8'h00);
    flush = 1;
    stepClock();
    applyIdle();
    checkOutput("uflow_err_after_flush", {7'b0, err}, 8'h01);

    // Asynchronous reset mid-cycle with cnt[3] = 2
    applyStimulus(3'd3);
    applyStimulus(3'd3);
    checkOutput("rst_pre", busy, 8'h08);
    #2 rst_n = 0;
    #1;
    checkOutput("rst_async_busy", busy, 8'h00);
    checkOutput("rst_async_err",  {7'b0, err}, 8'h00);
    dec_valid = 1; src1 = 3; src1_v = 1; src2 = 3; src2_v = 1;
    #1 checkOutput("rst_async_stall", {7'b0, stall}, 8'h00);
    stepClock();
    #3 rst_n = 1;
    applyIdle();
    stepClock();
    checkOutput("rst_release_busy", busy, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
